// File: rtl/ps2_pkg.sv
// Shared scan-code constants, event record and receiver state encoding
// for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_R     = 8'h2D;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = $bits(ps2_evt_t);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Keyboard status/response bytes that never represent a key.
    function automatic logic is_drop(input logic [7:0] c);
        case (c)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: line synchroniser and clock filter, frame FSM with
// watchdog, E0/F0 prefix decoder, held-key tracking and an event FIFO.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk100mhz,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [3:0] dir_held,
    output logic       reset_held,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       err_overflow
);

    localparam int FW  = $clog2(FILT_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0]  FILT_MAX = FW'(FILT_LEN - 1);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sync_clk;
    logic                   sync_data;

    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          fall_data;

    ps2_state_t     state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic           byte_ok;
    logic [WDW-1:0] wd_cnt;

    logic     ext_pend;
    logic     brk_pend;
    logic     evt_push;
    ps2_evt_t evt_wdata;

    logic [EVT_W-1:0] head_bits;
    ps2_evt_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             evt_pop;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];

    // Idle PS/2 lines are high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Filtered clock flips only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
            fall_data <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_clk == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk  <= sync_clk;
                filt_cnt  <= '0;
                fall      <= ~sync_clk;
                fall_data <= sync_data;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            byte_ok     <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            byte_ok     <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            if (fall) begin
                wd_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!fall_data) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {fall_data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= fall_data;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (!fall_data) begin
                            err_frame <= 1'b1;
                        end else if (^{shreg, par_bit}) begin
                            byte_ok <= 1'b1;
                        end else begin
                            err_parity <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (wd_cnt == WD_MAX) begin
                    state       <= IDLE;
                    err_timeout <= 1'b1;
                    wd_cnt      <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    // shreg stays stable from the STOP bit until the next frame's data bits.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            evt_push   <= 1'b0;
            evt_wdata  <= '0;
            dir_held   <= '0;
            reset_held <= 1'b0;
        end else begin
            evt_push <= 1'b0;
            if (err_parity || err_frame || err_timeout) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shreg == SC_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (!is_drop(shreg)) begin
                        evt_push       <= 1'b1;
                        evt_wdata.ext  <= ext_pend;
                        evt_wdata.brk  <= brk_pend;
                        evt_wdata.code <= shreg;
                        case (shreg)
                            SC_UP:    dir_held[3] <= ~brk_pend;
                            SC_DOWN:  dir_held[2] <= ~brk_pend;
                            SC_LEFT:  dir_held[1] <= ~brk_pend;
                            SC_RIGHT: dir_held[0] <= ~brk_pend;
                            SC_R:     reset_held  <= ~brk_pend;
                            default:  ;
                        endcase
                    end
                end
            end
        end
    end

    assign evt_pop = evt_valid & evt_ready;

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= evt_push & fifo_full & ~evt_pop;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk100mhz),
        .rst_n (rst_n),
        .push  (evt_push),
        .pop   (evt_pop),
        .wdata (evt_wdata),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head      = ps2_evt_t'(head_bits);
    assign evt_valid = ~fifo_empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames bit by bit and checks
// decoded events, held keys, error pulses and FIFO behaviour.
module tb_ps2_key_rx;

    localparam int HP = 30;
    localparam int TO = 300;

    logic       clk100mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [3:0] dir_held;
    logic       reset_held;
    logic       err_parity;
    logic       err_frame;
    logic       err_timeout;
    logic       err_overflow;

    int errors = 0;
    int checks = 0;
    int n_par  = 0;
    int n_frm  = 0;
    int n_to   = 0;
    int n_ovf  = 0;
    logic [9:0] evq[$];

    always #5 clk100mhz = ~clk100mhz;

    ps2_key_rx #(
        .SYNC_STAGES (2),
        .FILT_LEN    (8),
        .TIMEOUT_CYC (TO),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk100mhz    (clk100mhz),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .dir_held     (dir_held),
        .reset_held   (reset_held),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    // Inputs change just after posedge, so the negedge view is stable.
    always @(negedge clk100mhz) begin
        if (evt_valid && evt_ready) evq.push_back({evt_ext, evt_break, evt_code});
        if (err_parity)   n_par++;
        if (err_frame)    n_frm++;
        if (err_timeout)  n_to++;
        if (err_overflow) n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk100mhz);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        cyc(HP);
        ps2_clk = 1'b0;
        cyc(HP);
        ps2_clk = 1'b1;
        if (glitch) begin
            cyc(15);
            ps2_clk = 1'b0;
            cyc(7);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_at);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0, glitch_at == 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch_at == i + 1);
        ps2_bit(p, 1'b0);
        ps2_bit(~bad_stop, 1'b0);
        ps2_data = 1'b1;
        cyc(4 * HP);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, -1);
    endtask

    task automatic expect_evt(input string tag, input logic [9:0] exp);
        if (evq.size() == 0) check(tag, 32'hDEAD, {22'd0, exp});
        else                 check(tag, {22'd0, evq.pop_front()}, {22'd0, exp});
    endtask

    initial begin
        cyc(5);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_dir", {28'd0, dir_held}, 32'd0);
        check("rst_rheld", {31'd0, reset_held}, 32'd0);
        check("rst_errs", {28'd0, err_parity, err_frame, err_timeout, err_overflow}, 32'd0);
        rst_n = 1'b1;
        cyc(5);
        evt_ready = 1'b1;

        key(8'h75);
        expect_evt("up_make", 10'h075);
        check("up_held", {28'd0, dir_held}, 32'h8);
        key(8'hF0);
        key(8'h75);
        expect_evt("up_break", 10'h175);
        check("up_rel", {28'd0, dir_held}, 32'h0);

        key(8'hE0);
        key(8'h6B);
        expect_evt("left_make", 10'h26B);
        check("left_held", {28'd0, dir_held}, 32'h2);
        key(8'hE0);
        key(8'hF0);
        key(8'h6B);
        expect_evt("left_break", 10'h36B);
        check("left_rel", {28'd0, dir_held}, 32'h0);
        check("no_prefix_evt", evq.size(), 32'd0);

        send_frame(8'h2D, 1'b1, 1'b0, -1);
        check("par_pulse", n_par, 32'd1);
        check("par_noevt", evq.size(), 32'd0);
        check("par_rheld", {31'd0, reset_held}, 32'd0);
        send_frame(8'h2D, 1'b0, 1'b1, -1);
        check("frm_pulse", n_frm, 32'd1);
        send_frame(8'h2D, 1'b1, 1'b1, -1);
        check("frm_badpar_frm", n_frm, 32'd2);
        check("frm_badpar_par", n_par, 32'd1);
        check("frm_noevt", evq.size(), 32'd0);
        key(8'h2D);
        expect_evt("r_make", 10'h02D);
        check("r_held", {31'd0, reset_held}, 32'd1);
        key(8'hF0);
        key(8'h2D);
        expect_evt("r_break", 10'h12D);
        check("r_rel", {31'd0, reset_held}, 32'd0);

        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        for (int i = 0; i < TO + 200 && n_to == 0; i++) cyc(1);
        check("timeout", n_to, 32'd1);
        cyc(2);
        check("timeout_once", n_to, 32'd1);
        key(8'h72);
        expect_evt("after_to", 10'h072);
        check("down_held", {28'd0, dir_held}, 32'h4);
        key(8'hF0);
        key(8'h72);
        expect_evt("down_break", 10'h172);

        evt_ready = 1'b0;
        key(8'h1C);
        key(8'h32);
        key(8'h21);
        key(8'h23);
        check("ovf_none", n_ovf, 32'd0);
        key(8'h24);
        check("ovf_pulse", n_ovf, 32'd1);
        check("full_valid", {31'd0, evt_valid}, 32'd1);
        check("full_head", {24'd0, evt_code}, 32'h1C);
        evt_ready = 1'b1;
        cyc(10);
        expect_evt("drain0", 10'h01C);
        expect_evt("drain1", 10'h032);
        expect_evt("drain2", 10'h021);
        expect_evt("drain3", 10'h023);
        check("drain_empty", evq.size(), 32'd0);
        check("drain_valid", {31'd0, evt_valid}, 32'd0);

        send_frame(8'h74, 1'b0, 1'b0, 3);
        expect_evt("glitch_evt", 10'h074);
        check("glitch_held", {28'd0, dir_held}, 32'h1);
        check("glitch_noerr", n_par + n_frm, 32'd3);

        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(3);
        check("midrst_dir", {28'd0, dir_held}, 32'h0);
        check("midrst_valid", {31'd0, evt_valid}, 32'd0);
        ps2_data = 1'b1;
        rst_n = 1'b1;
        cyc(4 * HP);
        key(8'h6B);
        expect_evt("post_rst", 10'h06B);
        check("post_rst_held", {28'd0, dir_held}, 32'h2);
        check("final_errs", n_par + n_frm + n_to + n_ovf, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
